hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage LEGv8 core. It tracks destination registers of in-flight instructions in a shadow pipeline (EX/MEM/WB) and drives the EX-operand forwarding selects. It detects load-use hazards and stalls IF/ID for one cycle. It squashes wrong-path instructions when a branch resolves taken in EX. It sits beside the pipeline registers and replaces the per-operand address comparators with one sequenced unit.

---
 rtl/hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage LEGv8 core.
//
// A shadow pipeline (EX/MEM/WB) tracks the destination registers of the
// instructions in flight. From it the block selects the EX operand
// forwarding sources, detects load-use hazards and handles squashing after
// a taken branch.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   id_valid              ID stage holds a real instruction
//   id_rn/id_rm/id_rd     source and destination registers of the ID instr
//   id_uses_rn/_rm        ID instruction actually reads Rn / Rm
//   id_regwrite/_memread  control bits of the ID instruction
//   ex_br_taken           branch in EX resolved taken this cycle
//   fwd_a, fwd_b          EX operand select: 00 regfile, 01 MEM, 10 WB
//   stall_if_id           hold PC and IF/ID
//   bubble_ex             load a NOP into ID/EX
//   flush                 clear IF/ID, squash the ID instruction
//   stall_cnt, flush_cnt  saturating event counters
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal issue; load-use and taken branches are detected here
// STALL | one-cycle load-use bubble; the load has moved on to MEM
// FLUSH | remaining wrong-path squash cycles after a taken branch
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_br_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t     state;
    logic [1:0] flush_ctr;

    // EX keeps the full source information for forwarding; MEM and WB only
    // need what a later stage can match against.
    logic       ex_valid, ex_uses_rn, ex_uses_rm, ex_regwrite, ex_memread;
    logic [4:0] ex_rn, ex_rm, ex_rd;
    logic       mem_valid, mem_regwrite;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_regwrite;
    logic [4:0] wb_rd;

    logic load_use;
    logic br_evt;

    // X31 reads as XZR, so a write to it never produces a value to forward.
    function automatic logic match(input logic [4:0] src, input logic vld,
                                   input logic rw, input logic [4:0] rd);
        return vld & rw & (rd == src) & (src != 5'd31);
    endfunction

    always_comb begin
        load_use = (state == RUN) & id_valid & ex_memread &
                   ((id_uses_rn & match(id_rn, ex_valid, ex_regwrite, ex_rd)) |
                    (id_uses_rm & match(id_rm, ex_valid, ex_regwrite, ex_rd)));
        // EX holds a bubble during FLUSH, so a branch indication there is stale.
        br_evt = ex_br_taken & (state != FLUSH);
    end

    // Outputs are gated by reset so they drop to zero as soon as it asserts,
    // even while ex_br_taken or the id_* inputs are still active.
    always_comb begin
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        flush       = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (!reset) begin
            if (br_evt || state == FLUSH) begin
                flush     = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if_id = 1'b1;
                bubble_ex   = 1'b1;
            end
            if (ex_valid && ex_uses_rn) begin
                if (match(ex_rn, mem_valid, mem_regwrite, mem_rd))
                    fwd_a = 2'b01;
                else if (match(ex_rn, wb_valid, wb_regwrite, wb_rd))
                    fwd_a = 2'b10;
            end
            if (ex_valid && ex_uses_rm) begin
                if (match(ex_rm, mem_valid, mem_regwrite, mem_rd))
                    fwd_b = 2'b01;
                else if (match(ex_rm, wb_valid, wb_regwrite, wb_rd))
                    fwd_b = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flush_ctr <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN, STALL: begin
                    if (br_evt) begin
                        if (FLUSH_CYCLES > 1) begin
                            state     <= FLUSH;
                            flush_ctr <= 2'(FLUSH_CYCLES - 1);
                        end else begin
                            state <= RUN;
                        end
                    end else if (load_use) begin
                        state <= STALL;
                    end else begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    flush_ctr <= flush_ctr - 2'd1;
                    if (flush_ctr <= 2'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase

            if (stall_if_id && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (br_evt && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_uses_rn   <= 1'b0;
            ex_uses_rm   <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rn        <= 5'd0;
            ex_rm        <= 5'd0;
            ex_rd        <= 5'd0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= 5'd0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= 5'd0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            if (bubble_ex || !id_valid) begin
                ex_valid    <= 1'b0;
                ex_uses_rn  <= 1'b0;
                ex_uses_rm  <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_rn       <= 5'd0;
                ex_rm       <= 5'd0;
                ex_rd       <= 5'd0;
            end else begin
                ex_valid    <= 1'b1;
                ex_uses_rn  <= id_uses_rn;
                ex_uses_rm  <= id_uses_rm;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                ex_rn       <= id_rn;
                ex_rm       <= id_rm;
                ex_rd       <= id_rd;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rn, id_rm, id_rd;
    logic             id_uses_rn, id_uses_rm, id_regwrite, id_memread;
    logic             ex_br_taken;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall_if_id, bubble_ex, flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int compared = 0;
    int mismatched = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_br_taken(ex_br_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the ID stage: valid, rd, rn, rm, uses_rn, uses_rm, regwrite, memread.
    task automatic drive_id(input logic v, input logic [4:0] rd, input logic [4:0] rn,
                            input logic [4:0] rm, input logic urn, input logic urm,
                            input logic rw, input logic mr);
        id_valid = v; id_rd = rd; id_rn = rn; id_rm = rm;
        id_uses_rn = urn; id_uses_rm = urm; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic nop();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        ex_br_taken = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_br_taken = 1'b1;
        drive_id(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        compared++; if (flush !== 1'b0) begin mismatched++; $display("FAIL reset_flush: got %0b expected 0", flush); end
        compared++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin mismatched++; $display("FAIL reset_stall_bubble: got %0b/%0b expected 0/0", stall_if_id, bubble_ex); end
        compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin mismatched++; $display("FAIL reset_fwd: got %0b/%0b expected 00/00", fwd_a, fwd_b); end
        tick(); tick();
        compared++; if (stall_cnt !== 0 || flush_cnt !== 0) begin mismatched++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        reset = 1'b0;
        ex_br_taken = 1'b0;
        nop();
        #1;
        compared++; if (stall_if_id !== 1'b0 || flush !== 1'b0) begin mismatched++; $display("FAIL reset_release: got stall %0b flush %0b expected 0/0", stall_if_id, flush); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0); // ADD X1,X2,X3
        tick();
        drive_id(1'b1, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0); // SUB X2,X1,X1
        #1;
        compared++; if (stall_if_id !== 1'b0) begin mismatched++; $display("FAIL b2b_no_stall: got %0b expected 0", stall_if_id); end
        tick();
        drive_id(1'b1, 5'd6, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0); // ORR X6,X1,X0
        #1;
        compared++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin mismatched++; $display("FAIL b2b_fwd_mem: got %0b/%0b expected 01/01", fwd_a, fwd_b); end
        tick();
        nop();
        #1;
        compared++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin mismatched++; $display("FAIL b2b_fwd_wb: got %0b/%0b expected 10/00", fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd3, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); // LDUR X3,[X10]
        tick();
        drive_id(1'b1, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); // ADD X4,X3,X5
        #1;
        compared++; if (stall_if_id !== 1'b1 || bubble_ex !== 1'b1) begin mismatched++; $display("FAIL lu_stall: got %0b/%0b expected 1/1", stall_if_id, bubble_ex); end
        exp_stall++;
        tick();
        #1;
        compared++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin mismatched++; $display("FAIL lu_one_cycle: got %0b/%0b expected 0/0", stall_if_id, bubble_ex); end
        compared++; if (stall_cnt !== CNT_W'(exp_stall)) begin mismatched++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
        tick();
        nop();
        #1;
        compared++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin mismatched++; $display("FAIL lu_fwd_wb: got %0b/%0b expected 10/00", fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_no_write();
        drive_id(1'b1, 5'd31, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); // LDUR XZR
        tick();
        drive_id(1'b1, 5'd4, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        compared++; if (stall_if_id !== 1'b0) begin mismatched++; $display("FAIL xzr_no_stall: got %0b expected 0", stall_if_id); end
        tick();
        nop();
        #1;
        compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin mismatched++; $display("FAIL xzr_fwd: got %0b/%0b expected 00/00", fwd_a, fwd_b); end
        drain();
        drive_id(1'b1, 5'd7, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1); // rd=7, regwrite=0
        tick();
        drive_id(1'b1, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        compared++; if (stall_if_id !== 1'b0) begin mismatched++; $display("FAIL nowr_no_stall: got %0b expected 0", stall_if_id); end
        tick();
        nop();
        #1;
        compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin mismatched++; $display("FAIL nowr_fwd: got %0b/%0b expected 00/00", fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_double_match();
        drive_id(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd12, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        nop();
        #1;
        compared++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin mismatched++; $display("FAIL dbl_fwd_mem_prio: got %0b/%0b expected 01/01", fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_branch_hazard();
        drive_id(1'b1, 5'd3, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); // LDUR X3
        tick();
        drive_id(1'b1, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); // dependent ADD
        ex_br_taken = 1'b1;
        #1;
        compared++; if (flush !== 1'b1 || stall_if_id !== 1'b0 || bubble_ex !== 1'b1) begin mismatched++; $display("FAIL br_prio: got flush %0b stall %0b bubble %0b expected 1/0/1", flush, stall_if_id, bubble_ex); end
        exp_flush++;
        tick();
        // Second flush cycle; a stale taken indication here must be ignored.
        drive_id(1'b1, 5'd20, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        compared++; if (flush !== 1'b1 || bubble_ex !== 1'b1) begin mismatched++; $display("FAIL br_flush_cycle2: got %0b/%0b expected 1/1", flush, bubble_ex); end
        compared++; if (flush_cnt !== CNT_W'(exp_flush)) begin mismatched++; $display("FAIL br_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); end
        tick();
        ex_br_taken = 1'b0;
        drive_id(1'b1, 5'd21, 5'd20, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        compared++; if (flush !== 1'b0 || stall_if_id !== 1'b0) begin mismatched++; $display("FAIL br_flush_end: got flush %0b stall %0b expected 0/0", flush, stall_if_id); end
        compared++; if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin mismatched++; $display("FAIL br_counters: got %0d/%0d expected %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); end
        tick();
        nop();
        #1;
        compared++; if (fwd_a !== 2'b00) begin mismatched++; $display("FAIL br_squashed: got %0b expected 00", fwd_a); end
        drain();
    endtask

    task automatic test_reset_mid();
        // Reset while in FLUSH.
        ex_br_taken = 1'b1;
        nop();
        tick();
        #2;
        compared++; if (flush !== 1'b1) begin mismatched++; $display("FAIL rstf_setup: got %0b expected 1", flush); end
        reset = 1'b1;
        #1;
        compared++; if (flush !== 1'b0 || bubble_ex !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin mismatched++; $display("FAIL rstf_async: got flush %0b bubble %0b cnt %0d/%0d expected 0", flush, bubble_ex, stall_cnt, flush_cnt); end
        tick();
        reset = 1'b0;
        ex_br_taken = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        tick();
        // Reset while in STALL.
        drive_id(1'b1, 5'd3, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        #2;
        compared++; if (stall_cnt !== 1) begin mismatched++; $display("FAIL rsts_setup: got %0d expected 1", stall_cnt); end
        reset = 1'b1;
        #1;
        compared++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0 || stall_cnt !== 0 || fwd_a !== 2'b00) begin mismatched++; $display("FAIL rsts_async: got stall %0b bubble %0b cnt %0d fwd %0b expected 0", stall_if_id, bubble_ex, stall_cnt, fwd_a); end
        tick();
        reset = 1'b0;
        drive_id(1'b1, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        compared++; if (stall_if_id !== 1'b0 || flush !== 1'b0) begin mismatched++; $display("FAIL rsts_first: got stall %0b flush %0b expected 0/0", stall_if_id, flush); end
        tick();
        nop();
        #1;
        compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin mismatched++; $display("FAIL rsts_first_fwd: got %0b/%0b expected 00/00", fwd_a, fwd_b); end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_no_write();
        test_double_match();
        test_branch_hazard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
